// File: rtl/updown_mod_counter.sv
// updown_mod_counter: N-bit up/down counter with a runtime modulus (0..max_val),
// synchronous clear and parallel load, wrap or saturate at the bounds,
// terminal-count flag, one-cycle bound-event pulse and sticky overflow flag.
module updown_mod_counter #(
  parameter int           N         = 4,
  parameter bit           SATURATE  = 1'b0,
  parameter logic [N-1:0] RESET_VAL = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] max_val,
  input  logic         ovf_clr,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         wrap,
  output logic         ovf
);

  localparam logic [N-1:0] ZERO_C = {N{1'b0}};
  localparam logic [N-1:0] ONE_C  = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic         ovf_q, ovf_d;
  logic         bound_evt_s;

  // Next-state selection with clr > load > en priority; flags a bound event
  // whenever a step is attempted past either end of the 0..max_val range.
  always_comb begin
    count_d     = count_q;
    bound_evt_s = 1'b0;
    if (clr) begin
      count_d = ZERO_C;
    end else if (load) begin
      // A load beyond the modulus is clamped, never treated as a bound event.
      if (load_val > max_val) begin
        count_d = max_val;
      end else begin
        count_d = load_val;
      end
    end else if (en) begin
      if (up) begin
        // ">=" also pulls an out-of-range count (after max_val shrank) back in.
        if (count_q >= max_val) begin
          bound_evt_s = 1'b1;
          count_d     = SATURATE ? max_val : ZERO_C;
        end else begin
          count_d = count_q + ONE_C;
        end
      end else begin
        if (count_q > max_val) begin
          // Out of range after a modulus change: snap to the top, no event.
          count_d = max_val;
        end else if (count_q == ZERO_C) begin
          bound_evt_s = 1'b1;
          count_d     = SATURATE ? ZERO_C : max_val;
        end else begin
          count_d = count_q - ONE_C;
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // Flag next-state: wrap pulses for each event edge, ovf is sticky with set winning over clear.
  always_comb begin
    wrap_d = bound_evt_s;
    ovf_d  = bound_evt_s | (ovf_q & ~ovf_clr);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Terminal count looks at the current count and direction only, regardless of en.
  always_comb begin
    if (up) begin
      tc = (count_q >= max_val);
    end else begin
      tc = (count_q == ZERO_C);
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: one wrap-mode and one saturate-mode
// instance (N=4, RESET_VAL=0) share the same stimulus; expectations are hand-derived.
module tb_updown_mod_counter;

  logic       clk;
  logic       reset;
  logic       en, up, clr, load, ovf_clr;
  logic [3:0] load_val, max_val;

  logic [3:0] count_w, count_s;
  logic       tc_w, tc_s, wrap_w, wrap_s, ovf_w, ovf_s;

  int n_assert = 0;
  int n_fail   = 0;

  updown_mod_counter #(.N(4), .SATURATE(1'b0), .RESET_VAL(4'd0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .max_val(max_val), .ovf_clr(ovf_clr),
    .count(count_w), .tc(tc_w), .wrap(wrap_w), .ovf(ovf_w)
  );

  updown_mod_counter #(.N(4), .SATURATE(1'b1), .RESET_VAL(4'd0)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .max_val(max_val), .ovf_clr(ovf_clr),
    .count(count_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, then settle just after the edge before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; ovf_clr = 1'b0;
    load_val = 4'd0; max_val = 4'd9;

    // Reset state
    step(); step();
    chk("rst_count_w", count_w, 0);
    chk("rst_wrap_w", wrap_w, 0);
    chk("rst_ovf_w", ovf_w, 0);
    chk("rst_count_s", count_s, 0);
    chk("rst_ovf_s", ovf_s, 0);
    reset = 1'b1;

    // Wrap up, max_val=9
    en = 1'b1; up = 1'b1;
    chk("tc_at_0_up", tc_w, 0);
    for (int i = 1; i <= 11; i++) begin
      step();
      chk($sformatf("up_count_w_%0d", i), count_w, i % 10);
      chk($sformatf("up_tc_w_%0d", i), tc_w, (i == 9) ? 1 : 0);
      chk($sformatf("up_wrap_w_%0d", i), wrap_w, (i == 10) ? 1 : 0);
      chk($sformatf("up_ovf_w_%0d", i), ovf_w, (i >= 10) ? 1 : 0);
      chk($sformatf("up_count_s_%0d", i), count_s, (i > 9) ? 9 : i);
      chk($sformatf("up_wrap_s_%0d", i), wrap_s, (i >= 10) ? 1 : 0);
    end

    // Down / saturate: load 2 then count down for 5 edges
    en = 1'b0; load = 1'b1; load_val = 4'd2;
    step();
    load = 1'b0;
    chk("ld2_count_s", count_s, 2);
    chk("ld2_wrap_s", wrap_s, 0);
    chk("ld2_count_w", count_w, 2);
    en = 1'b1; up = 1'b0;
    step(); chk("dn1_count_s", count_s, 1); chk("dn1_wrap_s", wrap_s, 0); chk("dn1_count_w", count_w, 1);
    step(); chk("dn2_count_s", count_s, 0); chk("dn2_wrap_s", wrap_s, 0); chk("dn2_tc_s", tc_s, 1);
    step(); chk("dn3_count_s", count_s, 0); chk("dn3_wrap_s", wrap_s, 1); chk("dn3_count_w", count_w, 9);
    chk("dn3_wrap_w", wrap_w, 1); chk("dn3_tc_w", tc_w, 0);
    step(); chk("dn4_count_s", count_s, 0); chk("dn4_wrap_s", wrap_s, 1); chk("dn4_count_w", count_w, 8);
    chk("dn4_wrap_w", wrap_w, 0);
    step(); chk("dn5_count_s", count_s, 0); chk("dn5_wrap_s", wrap_s, 1); chk("dn5_count_w", count_w, 7);

    // Priority and load clamp
    en = 1'b0; clr = 1'b1; load = 1'b1; load_val = 4'd5;
    step();
    chk("clr_over_load_w", count_w, 0); chk("clr_over_load_s", count_s, 0); chk("clr_wrap_s", wrap_s, 0);
    chk("clr_keeps_ovf_w", ovf_w, 1);
    clr = 1'b0; load_val = 4'd14; max_val = 4'd9;
    step();
    chk("ld_clamp_w", count_w, 9); chk("ld_clamp_s", count_s, 9);
    en = 1'b1; up = 1'b1; load_val = 4'd3;
    step();
    chk("ld_over_en_w", count_w, 3); chk("ld_over_en_wrap_w", wrap_w, 0);

    // Sticky ovf, with max_val=0 giving back-to-back events
    load = 1'b0; en = 1'b0; ovf_clr = 1'b1;
    step();
    chk("ovfclr_idle_w", ovf_w, 0); chk("ovfclr_idle_s", ovf_s, 0);
    ovf_clr = 1'b0; max_val = 4'd0; en = 1'b1; up = 1'b1;
    step();
    chk("mv0_count_w", count_w, 0); chk("mv0_count_s", count_s, 0);
    chk("mv0_ovf_w", ovf_w, 1); chk("mv0_wrap_w", wrap_w, 1); chk("mv0_tc_w", tc_w, 1);
    ovf_clr = 1'b1;
    step();
    chk("ovf_set_wins_w", ovf_w, 1); chk("ovf_set_wins_s", ovf_s, 1); chk("mv0_wrap2_w", wrap_w, 1);
    en = 1'b0;
    step();
    chk("ovfclr_after_w", ovf_w, 0); chk("wrap_drop_w", wrap_w, 0);
    ovf_clr = 1'b0;

    // Full range, max_val=15
    max_val = 4'd15; load = 1'b1; load_val = 4'd13;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    chk("fr_ld_w", count_w, 13);
    step(); chk("fr14_w", count_w, 14);
    step(); chk("fr15_w", count_w, 15); chk("fr15_tc_w", tc_w, 1); chk("fr15_wrap_w", wrap_w, 0);
    step(); chk("fr0_w", count_w, 0); chk("fr0_wrap_w", wrap_w, 1); chk("fr_sat_s", count_s, 15);
    chk("fr_sat_wrap_s", wrap_s, 1);
    step(); chk("fr1_w", count_w, 1); chk("fr1_wrap_w", wrap_w, 0);

    // Async reset mid-count: get count=7 with wrap=1 by wrapping down from 0
    max_val = 4'd7; load = 1'b1; load_val = 4'd0; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    step();
    chk("pre_rst_count_w", count_w, 7); chk("pre_rst_wrap_w", wrap_w, 1); chk("pre_rst_ovf_w", ovf_w, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_count_w", count_w, 0); chk("arst_wrap_w", wrap_w, 0); chk("arst_ovf_w", ovf_w, 0);
    chk("arst_count_s", count_s, 0);
    #1 reset = 1'b1; up = 1'b1; max_val = 4'd9;
    step();
    chk("resume_w", count_w, 1); chk("resume_s", count_s, 1);
    step();
    chk("resume2_w", count_w, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the free-running binary counter: N-bit up/down counter with runtime-programmable modulus, enable, synchronous clear and parallel load.
- Selectable wrap or saturate mode; terminal-count flag, one-cycle wrap pulse and sticky overflow flag.
- Used as the general timebase/event counter in the design (prescalers, timeouts, position counters).

Parameters:
- N, 4, counter width in bits (N >= 2).
- SATURATE, 0, 0 = wrap at bounds; 1 = hold at bounds.
- RESET_VAL, 0, value loaded into count on reset; must be <= 2^N-1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  count enable; one step per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  N  value for load.
- max_val  in  N  upper bound (modulus-1); range is 0..max_val.
- ovf_clr  in  1  clears sticky ovf.
- count  out  N  registered counter value.
- tc  out  1  terminal count, combinational from count/up/max_val.
- wrap  out  1  registered one-cycle pulse after a bound event.
- ovf  out  1  sticky bound-event flag.

Behaviour:
- Reset (reset=0, async, any time including mid-operation): count=RESET_VAL, wrap=0, ovf=0 immediately. Released state counts from the first posedge after reset goes high.
- Per-posedge priority: clr > load > en. Inactive inputs leave count held.
- clr: count<=0; wrap<=0; ovf unchanged.
- load: count<=min(load_val, max_val). No bound event, wrap<=0.
- en=1, up=1:
  - count < max_val: count+1.
  - count >= max_val: bound event. Wrap mode -> 0. Saturate mode -> max_val. This also pulls an out-of-range count back in range.
- en=1, up=0:
  - count > max_val: count<=max_val, no bound event.
  - 0 < count <= max_val: count-1.
  - count == 0: bound event. Wrap mode -> max_val. Saturate mode -> 0.
- All arithmetic is N-bit unsigned. Increment is never evaluated past 2^N-1: max_val=2^N-1 wraps naturally to 0, no extra bit.
- Bound event timing:
  - wrap=1 on the cycle after the event edge, for exactly one cycle. This holds in saturate mode too: wrap then means a saturation attempt.
  - Back-to-back events give wrap high continuously, e.g. max_val=0 with en=1.
- ovf: set by any bound event; cleared by ovf_clr. Same-cycle event and ovf_clr -> ovf=1 (set wins).
- tc = (up && count >= max_val) || (!up && count == 0). Independent of en. Latency 0 from inputs, 1 from count.
- max_val=0: range {0}. Count stays 0 and every enabled cycle is a bound event.
- max_val changed mid-count: takes effect the next edge, per the rules above. No glitch requirement on tc beyond combinational settle.
- count latency: new value visible one clock after the controlling input is sampled.

Test Plan (N=4, RESET_VAL=0):
- Wrap up: SATURATE=0, max_val=9, en=1, up=1 from reset -> count 0..9, 0; tc=1 while count=9; wrap=1 exactly one cycle when count=0 after 9; ovf=1 thereafter.
- Down/saturate: SATURATE=1, load load_val=2, then en=1, up=0 for 5 cycles -> count 2,1,0,0,0. wrap=1 on each cycle after an edge taken at 0; count never goes below 0.
- Priority/clamp:
  - clr=1, load=1, load_val=5 same cycle -> count=0.
  - Then load=1, load_val=14, max_val=9 -> count=9.
  - Then load=1 with en=1 -> load wins, no increment.
- Full range: max_val=15, SATURATE=0, count up from 13 -> 14,15,0. Wrap pulse after 15->0; no X or width overflow.
- Sticky ovf: force a bound event, then assert ovf_clr on the same cycle as a second bound event -> ovf stays 1. ovf_clr on an idle cycle -> ovf=0.
- Async reset mid-count: reset low between edges at count=7, wrap=1 -> count=0, wrap=0, ovf=0 without a clock edge. Counting resumes from 0 after release.
